regfile_sequencer: RTL and testbench

Command-driven micro-sequencer for the 8-entry register file (R1–R4, S1–S4). It accepts one command at a time over a valid/ready handshake and drives the register-file select and function lines cycle by cycle. It also drives the select for the register-file input bus. The block sits between the future instruction decoder and the register file, and is the only driver of those control lines.

---
 rtl/regfile_pkg.sv | 45 ++++
 rtl/rep_counter.sv | 30 +++
 rtl/regfile_sequencer.sv | 148 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings for the register-file micro-sequencer: function codes,
// read-select codes, opcodes and sequencer states.
package regfile_pkg;

  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  localparam logic [2:0] SEL_R1 = 3'd0;
  localparam logic [2:0] SEL_R2 = 3'd1;
  localparam logic [2:0] SEL_R3 = 3'd2;
  localparam logic [2:0] SEL_R4 = 3'd3;
  localparam logic [2:0] SEL_S1 = 3'd4;
  localparam logic [2:0] SEL_S2 = 3'd5;
  localparam logic [2:0] SEL_S3 = 3'd6;
  localparam logic [2:0] SEL_S4 = 3'd7;

  typedef enum logic [2:0] {
    OP_CLR  = 3'b000,
    OP_INC  = 3'b001,
    OP_DEC  = 3'b010,
    OP_LDI  = 3'b011,
    OP_MOV  = 3'b100,
    OP_SWAP = 3'b101,
    OP_ADDK = 3'b110,
    OP_RSV  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SW1,
    ST_SW2,
    ST_SW3,
    ST_REP,
    ST_DONE
  } state_e;

  // Active-low enable with bit 3 mapping to register index 0 (R1/S1).
  function automatic logic [3:0] sel_low(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/rep_counter.sv
// 4-bit loadable down-counter pacing ADDK; last_o flags the final repeat.
module rep_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       last_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == 4'd1);

endmodule

// File: rtl/regfile_sequencer.sv
// Command-driven micro-sequencer driving the R1-R4/S1-S4 register-file
// select and function lines, one command at a time over valid/ready.
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int IMM_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_dst,
  input  logic [1:0]       cmd_src,
  input  logic [3:0]       cmd_k,
  input  logic [IMM_W-1:0] cmd_imm,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       OutASel,
  output logic [2:0]       OutBSel,
  output logic [2:0]       FunSel,
  output logic [3:0]       RegSel,
  output logic [3:0]       ScrSel,
  output logic             ISel,
  output logic [IMM_W-1:0] Imm
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [1:0]       dst_q, src_q;
  logic [IMM_W-1:0] imm_q;
  logic             accept;
  logic             rep_dec;
  logic             rep_last;

  assign accept = cmd_valid && (state_q == ST_IDLE);

  rep_counter u_rep_counter (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .load_i     (accept && (op_e'(cmd_op) == OP_ADDK)),
    .load_val_i (cmd_k),
    .dec_i      (rep_dec),
    .last_o     (rep_last)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_CLR;
      dst_q   <= 2'd0;
      src_q   <= 2'd0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_e'(cmd_op);
        dst_q <= cmd_dst;
        src_q <= cmd_src;
        imm_q <= cmd_imm;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    FunSel  = FUN_DEC;
    OutASel = SEL_R1;
    ISel    = 1'b0;
    RegSel  = 4'b1111;
    ScrSel  = 4'b1111;
    done    = 1'b0;
    err     = 1'b0;
    rep_dec = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_SWAP: state_d = ST_SW1;
            OP_ADDK: state_d = (cmd_k != 4'd0) ? ST_REP : ST_DONE;
            OP_RSV:  state_d = ST_DONE;
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        RegSel  = sel_low(dst_q);
        state_d = ST_DONE;
        case (op_q)
          OP_CLR: FunSel = FUN_CLR;
          OP_INC: FunSel = FUN_INC;
          OP_DEC: FunSel = FUN_DEC;
          OP_LDI: FunSel = FUN_LOAD;
          OP_MOV: begin
            FunSel  = FUN_LOAD;
            OutASel = {1'b0, src_q};
            ISel    = 1'b1;
          end
          default: FunSel = FUN_DEC;
        endcase
      end
      // SWAP parks dst in S1, copies src into dst, then restores S1 into src.
      ST_SW1: begin
        FunSel  = FUN_LOAD;
        OutASel = {1'b0, dst_q};
        ISel    = 1'b1;
        ScrSel  = 4'b0111;
        state_d = ST_SW2;
      end
      ST_SW2: begin
        FunSel  = FUN_LOAD;
        OutASel = {1'b0, src_q};
        ISel    = 1'b1;
        RegSel  = sel_low(dst_q);
        state_d = ST_SW3;
      end
      ST_SW3: begin
        FunSel  = FUN_LOAD;
        OutASel = SEL_S1;
        ISel    = 1'b1;
        RegSel  = sel_low(src_q);
        state_d = ST_DONE;
      end
      ST_REP: begin
        FunSel  = FUN_INC;
        RegSel  = sel_low(dst_q);
        rep_dec = 1'b1;
        if (rep_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = (op_q == OP_RSV);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign OutBSel   = busy ? {1'b0, src_q} : 3'b000;
  assign Imm       = busy ? imm_q : '0;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized self-checking bench: a register-file model driven by the DUT's
// control lines is compared against a command-level reference of R1-R4/S1.
module tb_regfile_sequencer;

  localparam int IMM_W = 16;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [1:0]       cmd_dst = 2'd0;
  logic [1:0]       cmd_src = 2'd0;
  logic [3:0]       cmd_k = 4'd0;
  logic [IMM_W-1:0] cmd_imm = '0;
  logic             busy, done, err;
  logic [2:0]       OutASel, OutBSel, FunSel;
  logic [3:0]       RegSel, ScrSel;
  logic             ISel;
  logic [IMM_W-1:0] Imm;

  always #5 Clock = ~Clock;

  regfile_sequencer #(.IMM_W(IMM_W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src   (cmd_src),
    .cmd_k     (cmd_k),
    .cmd_imm   (cmd_imm),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .OutASel   (OutASel),
    .OutBSel   (OutBSel),
    .FunSel    (FunSel),
    .RegSel    (RegSel),
    .ScrSel    (ScrSel),
    .ISel      (ISel),
    .Imm       (Imm)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register file driven purely by the sequencer's control lines.
  logic [15:0] rf_r [4];
  logic [15:0] rf_s [4];
  int wr_reg = 0;
  int wr_scr = 0;

  function automatic logic [15:0] apply_fun(input logic [2:0] f, input logic [15:0] v,
                                            input logic [15:0] bus);
    case (f)
      3'b000:  return v - 16'd1;
      3'b001:  return v + 16'd1;
      3'b010:  return bus;
      3'b011:  return 16'd0;
      default: return v;
    endcase
  endfunction

  always @(posedge Clock) begin : rf_model
    logic [15:0] outa, bus;
    outa = OutASel[2] ? rf_s[OutASel[1:0]] : rf_r[OutASel[1:0]];
    bus  = ISel ? outa : Imm;
    for (int i = 0; i < 4; i++) begin
      if (!RegSel[3-i]) begin
        rf_r[i] = apply_fun(FunSel, rf_r[i], bus);
        wr_reg++;
      end
      if (!ScrSel[3-i]) begin
        rf_s[i] = apply_fun(FunSel, rf_s[i], bus);
        wr_scr++;
      end
    end
  end

  // Command-level reference of the architectural effect of each opcode.
  logic [15:0] ref_r [4];
  logic [15:0] ref_s1;

  task automatic ref_apply(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s,
                           input logic [3:0] k, input logic [15:0] imm);
    logic [15:0] t;
    case (op)
      3'd0: ref_r[d] = 16'd0;
      3'd1: ref_r[d] = ref_r[d] + 16'd1;
      3'd2: ref_r[d] = ref_r[d] - 16'd1;
      3'd3: ref_r[d] = imm;
      3'd4: ref_r[d] = ref_r[s];
      3'd5: begin
        t        = ref_r[d];
        ref_s1   = t;
        ref_r[d] = ref_r[s];
        ref_r[s] = t;
      end
      3'd6: ref_r[d] = ref_r[d] + 16'(k);
      default: ;
    endcase
  endtask

  task automatic compare_regs();
    for (int i = 0; i < 4; i++)
      check($sformatf("R%0d", i + 1), rf_r[i], ref_r[i]);
    check("S1", rf_s[0], ref_s1);
    check("S2_untouched", rf_s[1], 16'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check("ready_before_cmd", cmd_ready, 1'b1);
  endtask

  // Issue one command from a negedge; returns at a negedge with the DUT idle.
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s,
                         input logic [3:0] k, input logic [15:0] imm, input bit hold);
    int  lat, exp_reg, exp_scr, base_reg, base_scr;
    bit  seen;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = d;
    cmd_src   = s;
    cmd_k     = k;
    cmd_imm   = imm;
    base_reg  = wr_reg;
    base_scr  = wr_scr;
    case (op)
      3'd5:    begin lat = 3;      exp_reg = 2;      exp_scr = 1; end
      3'd6:    begin lat = int'(k); exp_reg = int'(k); exp_scr = 0; end
      3'd7:    begin lat = 0;      exp_reg = 0;      exp_scr = 0; end
      default: begin lat = 1;      exp_reg = 1;      exp_scr = 0; end
    endcase
    @(posedge Clock);
    ref_apply(op, d, s, k, imm);
    seen = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge Clock);
      if (hold) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_dst   = 2'($urandom_range(0, 3));
        cmd_src   = 2'($urandom_range(0, 3));
        cmd_k     = 4'($urandom_range(0, 15));
        cmd_imm   = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (cyc == 0 && lat > 0) begin
        check("busy_first", busy, 1'b1);
        check("ready_first", cmd_ready, 1'b0);
        check("outbsel", OutBSel, {1'b0, s});
      end
      if (done) begin
        seen      = 1'b1;
        cmd_valid = 1'b0;
        check("done_latency", cyc, lat);
        check("err", err, (op == 3'd7));
        check("busy_in_done", busy, 1'b1);
        check("reg_writes", wr_reg - base_reg, exp_reg);
        check("scr_writes", wr_scr - base_scr, exp_scr);
      end
    end
    if (!seen) check("done_timeout", 1'b0, 1'b1);
    @(negedge Clock);
    check("ready_after", cmd_ready, 1'b1);
    check("idle_regsel", RegSel, 4'hF);
    check("idle_done", done, 1'b0);
    compare_regs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rf_r[i]  = 16'd0;
      rf_s[i]  = 16'd0;
      ref_r[i] = 16'd0;
    end
    ref_s1 = 16'd0;

    // Reset values.
    repeat (2) @(negedge Clock);
    check("rst_regsel", RegSel, 4'hF);
    check("rst_scrsel", ScrSel, 4'hF);
    check("rst_funsel", FunSel, 3'd0);
    check("rst_outasel", OutASel, 3'd0);
    check("rst_outbsel", OutBSel, 3'd0);
    check("rst_isel", ISel, 1'b0);
    check("rst_imm", Imm, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    Reset = 1'b0;
    @(negedge Clock);

    // LDI then MOV.
    run_cmd(3'd3, 2'd2, 2'd0, 4'd0, 16'hA5A5, 1'b0);
    run_cmd(3'd4, 2'd0, 2'd2, 4'd0, 16'h0000, 1'b0);

    // SWAP R1 <-> R4.
    run_cmd(3'd3, 2'd0, 2'd0, 4'd0, 16'h1234, 1'b0);
    run_cmd(3'd3, 2'd3, 2'd0, 4'd0, 16'hBEEF, 1'b0);
    run_cmd(3'd5, 2'd0, 2'd3, 4'd0, 16'h0000, 1'b0);

    // ADDK wraps past 0xFFFF.
    run_cmd(3'd3, 2'd1, 2'd0, 4'd0, 16'hFFFE, 1'b0);
    run_cmd(3'd6, 2'd1, 2'd0, 4'd3, 16'h0000, 1'b0);

    // ADDK k=0 and reserved opcode: no writes, err only on reserved.
    run_cmd(3'd6, 2'd2, 2'd1, 4'd0, 16'h0000, 1'b0);
    run_cmd(3'd7, 2'd1, 2'd2, 4'd5, 16'h5555, 1'b0);

    // Aliased SWAP/MOV, then inputs churning while busy.
    run_cmd(3'd5, 2'd1, 2'd1, 4'd0, 16'h0000, 1'b0);
    run_cmd(3'd4, 2'd3, 2'd3, 4'd0, 16'h0000, 1'b1);
    run_cmd(3'd6, 2'd0, 2'd0, 4'd15, 16'h0000, 1'b1);
    run_cmd(3'd2, 2'd2, 2'd0, 4'd0, 16'h0000, 1'b1);

    for (int n = 0; n < 40; n++)
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 6)), 16'($urandom), 1'($urandom_range(0, 1)));

    // Reset during SW2: outputs return to idle at once; S1 keeps old R1.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_dst   = 2'd0;
    cmd_src   = 2'd1;
    @(posedge Clock);
    @(negedge Clock);
    cmd_valid = 1'b0;
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("midrst_regsel", RegSel, 4'hF);
    check("midrst_scrsel", ScrSel, 4'hF);
    check("midrst_ready", cmd_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    ref_s1 = ref_r[0];
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    compare_regs();
    run_cmd(3'd1, 2'd0, 2'd0, 4'd0, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
